// File: rtl/sw_debounce_mode.sv
// Switch front end: two-flop synchroniser, per-bit debounce with edge pulses,
// and a 2-bit display-mode register stepped by rising edges on switches 0 and 1.
module sw_debounce_mode #(
  parameter int N_SW    = 2,
  parameter int DEB_CNT = 20000,
  parameter int CNT_W   = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw_level,
  output logic [N_SW-1:0] o_sw_rise,
  output logic [N_SW-1:0] o_sw_fall,
  output logic [1:0]      o_mode,
  output logic            o_mode_chg
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_SW-1:0] sync1;
  logic [N_SW-1:0] sync2;

  // NOTE: every state register uses non-blocking assignments and the async
  // reset branch, so all flops update together and clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_sw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    deb_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level, level_nx;
    logic             rise, rise_nx;
    logic             fall, fall_nx;

    // NOTE: each always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
        ST_STABLE: begin
          if (sync2[i] != level) begin
            state_nx = ST_COUNTING;
            cnt_nx   = CNT_ONE;
          end
        end
        ST_COUNTING: begin
          if (sync2[i] == level) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            // DEB_CNT-th consecutive mismatch: accept the new level.
            state_nx = ST_STABLE;
            cnt_nx   = '0;
            level_nx = ~level;
            rise_nx  = ~level;
            fall_nx  = level;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_STABLE;
        cnt   <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        level <= level_nx;
        rise  <= rise_nx;
        fall  <= fall_nx;
      end
    end

    assign o_sw_level[i] = level;
    assign o_sw_rise[i]  = rise;
    assign o_sw_fall[i]  = fall;
  end

  logic [1:0] mode_nx;
  logic       mode_chg_nx;

  // Both rises in one cycle are treated as a "home" gesture.
  always_comb begin
    mode_nx     = o_mode;
    mode_chg_nx = 1'b0;
    case (o_sw_rise[1:0])
      2'b01: begin
        mode_nx     = o_mode + 2'd1;
        mode_chg_nx = 1'b1;
      end
      2'b10: begin
        mode_nx     = o_mode - 2'd1;
        mode_chg_nx = 1'b1;
      end
      2'b11: begin
        mode_nx     = 2'd0;
        mode_chg_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mode     <= 2'd0;
      o_mode_chg <= 1'b0;
    end else begin
      o_mode     <= mode_nx;
      o_mode_chg <= mode_chg_nx;
    end
  end

endmodule
